fetch_if_id_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of ID-stage hazard detection.

---
 rtl/fetch_if_id_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_fetch_if_id_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_if_id_stage.sv
// -----------------------------------------------------------------------------
// fetch_if_id_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register. Owns the program
// counter, runs a req/ack handshake with instruction memory and presents
// {valid, pc, inst, pc+4} to the decode stage. Holds on a load-use stall from
// the hazard unit and flushes/re-steers on a taken branch/jump from EX.
//
// Parameters
//   XLEN      datapath / PC width
//   RESET_PC  PC loaded at reset
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   stall                          load-use stall from hazard detection
//   redirect_valid, redirect_pc    EX-stage re-steer; target low two bits ignored
//   imem_req, imem_addr            fetch request / address to instruction memory
//   imem_ack, imem_rdata           memory response; transfer = imem_req & imem_ack
//   if_id_valid, if_id_pc,
//   if_id_inst, if_id_pc_plus4     IF/ID register contents (inst = NOP when invalid)
//   perf_stall_cnt                 saturating count of stall cycles
//   perf_bubble_cnt                saturating count of bubble/flush writes
//
// Build option
//   FETCH_PERF_EN  when defined, the two performance counters are implemented;
//                  otherwise both perf ports are tied to zero and no counter
//                  flops exist.
// -----------------------------------------------------------------------------
module fetch_if_id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_bubble_cnt
);

  localparam logic [31:0]     NOP       = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Word-align a PC; the low two bits never reach the memory port.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ALIGN_MSK;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  state_t          state, state_nxt;
  logic            started;

  // Fetch stage (p0): PC, address of an abandoned-but-outstanding request,
  // and the skid entry captured when an ack lands during a stall. The skid
  // PC is not stored: the PC does not advance while HELD, so it equals pc_p0.
  logic [XLEN-1:0] pc_p0, pc_p0_nxt;
  logic [XLEN-1:0] drain_addr_p0, drain_addr_p0_nxt;
  logic [31:0]     skid_inst_p0, skid_inst_p0_nxt;

  // IF/ID register (p1)
  logic            vld_p1, vld_p1_nxt;
  logic [XLEN-1:0] pc_p1, pc_p1_nxt;
  logic [31:0]     inst_p1, inst_p1_nxt;
  logic [XLEN-1:0] pc4_p1, pc4_p1_nxt;

  logic            transfer;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_tgt;

  // The request is suppressed until the first edge after reset release, and
  // while HELD (the fetched word is parked in the skid entry).
  assign imem_req     = started && (state != HELD);
  assign imem_addr    = (state == DRAIN) ? drain_addr_p0 : pc_p0;
  assign transfer     = imem_req && imem_ack;
  assign pc_inc       = pc_p0 + PC_STEP;
  assign redirect_tgt = align_pc(redirect_pc);

  always_comb begin
    state_nxt          = state;
    pc_p0_nxt          = pc_p0;
    drain_addr_p0_nxt  = drain_addr_p0;
    skid_inst_p0_nxt   = skid_inst_p0;
    vld_p1_nxt         = vld_p1;
    pc_p1_nxt          = pc_p1;
    inst_p1_nxt        = inst_p1;
    pc4_p1_nxt         = pc4_p1;

    case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_p0_nxt        = redirect_tgt;
          vld_p1_nxt       = 1'b0;
          inst_p1_nxt      = NOP;
          skid_inst_p0_nxt = NOP;
          // An un-acked request must still be completed at its old address.
          if (imem_req && !imem_ack) begin
            state_nxt         = DRAIN;
            drain_addr_p0_nxt = pc_p0;
          end
        end else if (transfer && !stall) begin
          vld_p1_nxt  = 1'b1;
          pc_p1_nxt   = pc_p0;
          inst_p1_nxt = imem_rdata;
          pc4_p1_nxt  = pc_inc;
          pc_p0_nxt   = pc_inc;
        end else if (transfer) begin
          skid_inst_p0_nxt = imem_rdata;
          state_nxt        = HELD;
        end else if (!stall) begin
          vld_p1_nxt  = 1'b0;
          inst_p1_nxt = NOP;
        end
      end

      HELD: begin
        if (redirect_valid) begin
          pc_p0_nxt        = redirect_tgt;
          vld_p1_nxt       = 1'b0;
          inst_p1_nxt      = NOP;
          skid_inst_p0_nxt = NOP;
          state_nxt        = FETCH;
        end else if (!stall) begin
          vld_p1_nxt       = 1'b1;
          pc_p1_nxt        = pc_p0;
          inst_p1_nxt      = skid_inst_p0;
          pc4_p1_nxt       = pc_inc;
          pc_p0_nxt        = pc_inc;
          skid_inst_p0_nxt = NOP;
          state_nxt        = FETCH;
        end
      end

      DRAIN: begin
        // IF/ID is already invalid; only the re-steer target may change.
        if (redirect_valid) begin
          pc_p0_nxt = redirect_tgt;
        end
        if (imem_ack) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // ---- fetch stage (p0) state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      started       <= 1'b0;
      pc_p0         <= RESET_PC;
      drain_addr_p0 <= '0;
      skid_inst_p0  <= NOP;
    end else begin
      state         <= state_nxt;
      started       <= 1'b1;
      pc_p0         <= pc_p0_nxt;
      drain_addr_p0 <= drain_addr_p0_nxt;
      skid_inst_p0  <= skid_inst_p0_nxt;
    end
  end

  // ---- IF/ID boundary (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      inst_p1 <= NOP;
      pc4_p1  <= '0;
    end else begin
      vld_p1  <= vld_p1_nxt;
      pc_p1   <= pc_p1_nxt;
      inst_p1 <= inst_p1_nxt;
      pc4_p1  <= pc4_p1_nxt;
    end
  end

  assign if_id_valid    = vld_p1;
  assign if_id_pc       = pc_p1;
  assign if_id_inst     = inst_p1;
  assign if_id_pc_plus4 = pc4_p1;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic        bubble_wr;

  // IF/ID valid is cleared by a redirect in any state, or by a fetch cycle
  // that neither transferred nor stalled.
  assign bubble_wr = redirect_valid || ((state == FETCH) && !transfer && !stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (bubble_wr) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_stall_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_if_id_stage.sv
module tb_fetch_if_id_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;

  int n_total = 0;
  int n_pass  = 0;

  fetch_if_id_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_inst      (if_id_inst),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ack;
    logic        rdv;
    logic [31:0] rpc;
    logic [31:0] rdata;
    logic        exp_req;    // before the edge
    logic [31:0] exp_addr;   // before the edge, checked only when exp_req
    logic        exp_vld;    // after the edge
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_p4;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic a, input logic rv,
                              input logic [31:0] rp, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei, input logic [31:0] e4);
    vec_t v;
    v.stall = s; v.ack = a; v.rdv = rv; v.rpc = rp; v.rdata = rd;
    v.exp_req = er; v.exp_addr = ea; v.exp_vld = ev;
    v.exp_pc = ep; v.exp_inst = ei; v.exp_p4 = e4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] i, input logic [31:0] p4);
    chk({tag, " valid"}, {31'b0, if_id_valid}, {31'b0, v});
    chk({tag, " pc"},    if_id_pc, p);
    chk({tag, " inst"},  if_id_inst, i);
    chk({tag, " pc4"},   if_id_pc_plus4, p4);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    string tag;
    v = vecs[k];
    tag = $sformatf("v%0d", k);
    stall = v.stall; imem_ack = v.ack; redirect_valid = v.rdv;
    redirect_pc = v.rpc; imem_rdata = v.rdata;
    #1;
    chk({tag, " req"}, {31'b0, imem_req}, {31'b0, v.exp_req});
    if (v.exp_req) chk({tag, " addr"}, imem_addr, v.exp_addr);
    @(posedge clk); #1;
    chk_ifid(tag, v.exp_vld, v.exp_pc, v.exp_inst, v.exp_p4);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rdata = JUNK;
  endtask

  logic [31:0] s0, b0;

  initial begin
    // stall, ack, rdv, rpc, rdata | req, addr | vld, pc, inst, pc4
    // Straight-line fetch with ack every cycle.
    vecs[0]  = mk(0,1,0,0,JUNK,         0,32'h0,   0,32'h0, NOP,          32'h0);
    vecs[1]  = mk(0,1,0,0,32'hA000_0000,1,32'h0,   1,32'h0, 32'hA000_0000,32'h4);
    vecs[2]  = mk(0,1,0,0,32'hA000_0001,1,32'h4,   1,32'h4, 32'hA000_0001,32'h8);
    // ack low for three cycles at pc=8
    vecs[3]  = mk(0,0,0,0,JUNK,         1,32'h8,   0,32'h4, NOP,          32'h8);
    vecs[4]  = mk(0,0,0,0,JUNK,         1,32'h8,   0,32'h4, NOP,          32'h8);
    vecs[5]  = mk(0,0,0,0,JUNK,         1,32'h8,   0,32'h4, NOP,          32'h8);
    vecs[6]  = mk(0,1,0,0,32'hA000_0002,1,32'h8,   1,32'h8, 32'hA000_0002,32'hC);
    // stall on the ack for pc=C -> HELD, then release
    vecs[7]  = mk(1,1,0,0,32'hA000_0003,1,32'hC,   1,32'h8, 32'hA000_0002,32'hC);
    vecs[8]  = mk(1,0,0,0,JUNK,         0,32'hC,   1,32'h8, 32'hA000_0002,32'hC);
    vecs[9]  = mk(0,0,0,0,JUNK,         0,32'hC,   1,32'hC, 32'hA000_0003,32'h10);
    vecs[10] = mk(0,1,0,0,32'hA000_0004,1,32'h10,  1,32'h10,32'hA000_0004,32'h14);
    vecs[11] = mk(0,1,0,0,32'hA000_0005,1,32'h14,  1,32'h14,32'hA000_0005,32'h18);
    vecs[12] = mk(0,1,0,0,32'hA000_0006,1,32'h18,  1,32'h18,32'hA000_0006,32'h1C);
    vecs[13] = mk(0,1,0,0,32'hA000_0007,1,32'h1C,  1,32'h1C,32'hA000_0007,32'h20);
    // redirect to 0x103 with no ack at pc=0x20 -> DRAIN
    vecs[14] = mk(0,0,1,32'h103,JUNK,   1,32'h20,  0,32'h1C,NOP,          32'h20);
    vecs[15] = mk(0,0,0,0,JUNK,         1,32'h20,  0,32'h1C,NOP,          32'h20);
    vecs[16] = mk(0,1,0,0,JUNK,         1,32'h20,  0,32'h1C,NOP,          32'h20);
    vecs[17] = mk(0,1,0,0,32'hA000_0008,1,32'h100, 1,32'h100,32'hA000_0008,32'h104);
    // stall into HELD, then redirect+stall together
    vecs[18] = mk(1,1,0,0,32'hA000_0009,1,32'h104, 1,32'h100,32'hA000_0008,32'h104);
    vecs[19] = mk(1,0,1,32'h200,JUNK,   0,32'h104, 0,32'h100,NOP,          32'h104);
    vecs[20] = mk(0,1,0,0,32'hA000_000A,1,32'h200, 1,32'h200,32'hA000_000A,32'h204);
    // redirect in the same cycle as a transfer: data dropped, stay FETCH
    vecs[21] = mk(0,1,1,32'h300,JUNK,   1,32'h204, 0,32'h200,NOP,          32'h204);
    vecs[22] = mk(0,1,0,0,32'hA000_000B,1,32'h300, 1,32'h300,32'hA000_000B,32'h304);
    // stall without transfer: IF/ID holds
    vecs[23] = mk(1,0,0,0,JUNK,         1,32'h304, 1,32'h300,32'hA000_000B,32'h304);
    // redirect overrides stall; target to top of address space, then wrap
    vecs[24] = mk(1,1,1,32'hFFFF_FFFF,JUNK,1,32'h304,0,32'h300,NOP,       32'h304);
    vecs[25] = mk(0,1,0,0,32'hA000_000C,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'hA000_000C,32'h0);
    vecs[26] = mk(0,0,0,0,JUNK,         1,32'h0,   0,32'hFFFF_FFFC,NOP,   32'h0);
    // redirect into DRAIN, retarget while draining, then complete
    vecs[27] = mk(0,0,1,32'h40,JUNK,    1,32'h0,   0,32'hFFFF_FFFC,NOP,   32'h0);
    vecs[28] = mk(0,0,1,32'h82,JUNK,    1,32'h0,   0,32'hFFFF_FFFC,NOP,   32'h0);
    vecs[29] = mk(0,1,0,0,JUNK,         1,32'h0,   0,32'hFFFF_FFFC,NOP,   32'h0);
    vecs[30] = mk(0,1,0,0,32'hA000_000D,1,32'h80,  1,32'h80,32'hA000_000D,32'h84);

    // Reset state
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", {31'b0, imem_req}, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, NOP, 32'h0);
    chk("rst stall_cnt", perf_stall_cnt, 32'h0);
    chk("rst bubble_cnt", perf_bubble_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) run_vec(k);

    // Counters: 5 stall cycles (fetch, no ack) then 2 bubbles.
    idle_inputs();
    s0 = perf_stall_cnt;
    b0 = perf_bubble_cnt;
    stall = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef FETCH_PERF_EN
    chk("perf stall delta", perf_stall_cnt - s0, 32'd5);
    chk("perf bubble delta", perf_bubble_cnt - b0, 32'd2);
`else
    chk("perf stall tied", perf_stall_cnt, 32'h0);
    chk("perf bubble tied", perf_bubble_cnt, 32'h0);
`endif
    chk("perf seq ifid valid", {31'b0, if_id_valid}, 32'h0);
    chk("perf seq addr", imem_addr, 32'h84);

    // Enter DRAIN, then assert reset mid-cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    @(posedge clk); #1;
    idle_inputs();
    chk("drain req", {31'b0, imem_req}, 32'h1);
    chk("drain addr", imem_addr, 32'h84);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst req", {31'b0, imem_req}, 32'h0);
    chk_ifid("async rst", 1'b0, 32'h0, NOP, 32'h0);
    chk("async rst stall_cnt", perf_stall_cnt, 32'h0);
    chk("async rst bubble_cnt", perf_bubble_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hA000_000E;
    #1;
    chk("post rst req low", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;
    chk("post rst req", {31'b0, imem_req}, 32'h1);
    chk("post rst addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    chk_ifid("post rst fetch", 1'b1, 32'h0, 32'hA000_000E, 32'h4);
    chk("post rst next addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
